// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8002_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - fetch PC register with increment/redirect mux and pending redirect target
module fetch_pc
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_hold_target,
    input  logic        i_advance,
    input  logic        i_take_target,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic [31:0] w_target;

    assign w_target = i_redirect_pc & WORD_ALIGN_MASK;
    assign o_pc     = r_pc;

    // A redirect either retargets the PC directly or, while an old request must still
    // drain, parks the target; the parked target is loaded once the drain completes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc     <= RESET_PC;
            r_target <= RESET_PC;
        end else if (i_redirect) begin
            if (i_hold_target) begin
                r_target <= w_target;
            end else begin
                r_pc <= w_target;
            end
        end else if (i_advance) begin
            r_pc <= r_pc + 32'(PC_STEP);
        end else if (i_take_target) begin
            r_pc <= r_target;
        end
    end

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - single-outstanding instruction fetch stage with redirect and drain
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [0:31] insn,
    output logic        insn_valid,
    output logic [31:0] insn_pc
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic        r_busy;
    logic [0:31] r_insn;
    logic [31:0] r_insn_pc;
    logic        r_insn_valid;

    logic        w_slot_free;
    logic        w_issue;
    logic        w_pending_next;
    logic        w_accept;
    logic        w_drain_done;
    logic [31:0] w_pc;

    // A new request only starts when the output slot will be free next cycle and no
    // redirect is arriving; an outstanding request keeps mem_req up until its ack.
    assign w_slot_free    = !r_insn_valid || !stall;
    assign w_issue        = (r_state == S_FETCH) && enable && w_slot_free && !redirect && !r_busy;
    assign mem_req        = r_busy || w_issue;
    assign mem_addr       = w_pc;
    assign w_pending_next = mem_req && !mem_ack;
    assign w_accept       = (r_state == S_FETCH) && mem_req && mem_ack && !redirect;
    assign w_drain_done   = (r_state == S_DRAIN) && mem_ack && !redirect;

    assign insn       = r_insn;
    assign insn_pc    = r_insn_pc;
    assign insn_valid = r_insn_valid;

    fetch_pc #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_fetch_pc (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_hold_target (w_pending_next),
        .i_advance     (w_accept),
        .i_take_target (w_drain_done),
        .o_pc          (w_pc)
    );

    // State register plus the outstanding-request flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_pending_next;
        end
    end

    // Next state: a redirect that cannot complete this cycle drains the old request first
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (redirect && w_pending_next) begin
                    w_state_next = S_DRAIN;
                end else if (!enable && !w_pending_next) begin
                    w_state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mem_ack) begin
                    w_state_next = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output slot: flush on redirect, load on an accepted ack, empty once decode takes it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_insn       <= NOP;
            r_insn_pc    <= '0;
            r_insn_valid <= 1'b0;
        end else if (redirect) begin
            r_insn_valid <= 1'b0;
        end else if (w_accept) begin
            r_insn       <= mem_rdata;
            r_insn_pc    <= mem_addr;
            r_insn_valid <= 1'b1;
        end else if (r_insn_valid && !stall) begin
            r_insn_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - self-checking bench for the fetch stage
module tb_fetch;

    localparam logic [31:0] RST_PC = 32'h8002_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [0:31] insn;
    logic        insn_valid;
    logic [31:0] insn_pc;

    int n_pass = 0;
    int n_total = 0;

    int          lat = 0;
    logic [31:0] slow_addr = 32'h1;
    int          slow_lat = 0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_addr = '0;
    logic [31:0] ovr_data = '0;
    int          wait_cnt = -1;

    fetch #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .insn        (insn),
        .insn_valid  (insn_valid),
        .insn_pc     (insn_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr_en && a == ovr_addr) return ovr_data;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory model: per-request latency, garbage on rdata when not acking
    always begin
        @(posedge clock);
        #2;
        if (!reset_n || !mem_req) begin
            mem_ack = 1'b0;
            if (!reset_n) wait_cnt = -1;
        end else begin
            if (wait_cnt < 0)
                wait_cnt = (mem_addr == slow_addr) ? slow_lat
                         : ((lat < 0) ? int'($urandom_range(0, 3)) : lat);
            if (wait_cnt == 0) begin
                mem_ack = 1'b1;
                mem_rdata = mem_word(mem_addr);
                wait_cnt = -1;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                wait_cnt--;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        reset_n = 1'b0;
        enable = 1'b1;
        #1;
        n_total++; if (mem_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", mem_req); else n_pass++;
        n_total++; if (mem_addr !== RST_PC) $display("FAIL rst_addr got=%h exp=%h", mem_addr, RST_PC); else n_pass++;
        n_total++; if (insn !== 32'h0) $display("FAIL rst_insn got=%h exp=0", insn); else n_pass++;
        n_total++; if (insn_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", insn_valid); else n_pass++;
        n_total++; if (insn_pc !== 32'h0) $display("FAIL rst_insn_pc got=%h exp=0", insn_pc); else n_pass++;
        tick(); tick();
        #2;
        n_total++; if (mem_req !== 1'b0) $display("FAIL rst_hold_req got=%b exp=0", mem_req); else n_pass++;
    endtask

    task automatic test_zero_wait();
        lat = 0;
        do_reset();
        tick();
        enable = 1'b1;
        #2;
        n_total++; if (mem_req !== 1'b0) $display("FAIL zw_early_req got=%b exp=0", mem_req); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            #2;
            n_total++; if (mem_req !== 1'b1) $display("FAIL zw_req k=%0d got=%b exp=1", k, mem_req); else n_pass++;
            n_total++; if (mem_addr !== RST_PC + 32'(4 * k)) $display("FAIL zw_addr got=%h exp=%h", mem_addr, RST_PC + 32'(4 * k)); else n_pass++;
            if (k > 0) begin
                n_total++; if (insn_valid !== 1'b1) $display("FAIL zw_valid k=%0d got=%b exp=1", k, insn_valid); else n_pass++;
                n_total++; if (insn_pc !== RST_PC + 32'(4 * (k - 1))) $display("FAIL zw_insn_pc got=%h exp=%h", insn_pc, RST_PC + 32'(4 * (k - 1))); else n_pass++;
                n_total++; if (insn !== mem_word(RST_PC + 32'(4 * (k - 1)))) $display("FAIL zw_insn got=%h exp=%h", insn, mem_word(RST_PC + 32'(4 * (k - 1)))); else n_pass++;
            end
        end
    endtask

    task automatic test_wait_states();
        bit found = 0;
        lat = 3;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            #2;
            if (mem_req) found = 1;
        end
        n_total++; if (!found) $display("FAIL ws_first_req got=none exp=request"); else n_pass++;
        for (int j = 0; j <= 8; j++) begin
            if (j > 0) begin tick(); #2; end
            if (j < 8) begin
                n_total++; if (mem_req !== 1'b1) $display("FAIL ws_req j=%0d got=%b exp=1", j, mem_req); else n_pass++;
                n_total++; if (mem_addr !== RST_PC + 32'(4 * (j / 4))) $display("FAIL ws_addr j=%0d got=%h exp=%h", j, mem_addr, RST_PC + 32'(4 * (j / 4))); else n_pass++;
                n_total++; if (insn_valid !== (j == 4)) $display("FAIL ws_valid j=%0d got=%b exp=%b", j, insn_valid, (j == 4)); else n_pass++;
            end else begin
                n_total++; if (insn_valid !== 1'b1 || insn_pc !== RST_PC + 32'h4) $display("FAIL ws_second got=%b/%h exp=1/%h", insn_valid, insn_pc, RST_PC + 32'h4); else n_pass++;
            end
        end
        lat = 0;
    endtask

    task automatic test_stall();
        bit found = 0;
        logic [31:0] t = RST_PC + 32'h8;
        lat = 0;
        ovr_en = 1'b1; ovr_addr = t; ovr_data = 32'h2408_0005;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (insn_valid && insn_pc == t) begin stall = 1'b1; found = 1; end
        end
        n_total++; if (!found) $display("FAIL st_target got=none exp=%h", t); else n_pass++;
        for (int s = 0; s < 4; s++) begin
            if (s > 0) tick();
            #2;
            n_total++; if (insn !== 32'h2408_0005) $display("FAIL st_insn s=%0d got=%h exp=24080005", s, insn); else n_pass++;
            n_total++; if (insn_pc !== t || insn_valid !== 1'b1) $display("FAIL st_pc s=%0d got=%h/%b exp=%h/1", s, insn_pc, insn_valid, t); else n_pass++;
            n_total++; if (mem_req !== 1'b0) $display("FAIL st_noreq s=%0d got=%b exp=0", s, mem_req); else n_pass++;
        end
        tick();
        stall = 1'b0;
        #2;
        n_total++; if (mem_req !== 1'b1 || mem_addr !== t + 32'h4) $display("FAIL st_resume got=%b/%h exp=1/%h", mem_req, mem_addr, t + 32'h4); else n_pass++;
        tick();
        #2;
        n_total++; if (insn_valid !== 1'b1 || insn_pc !== t + 32'h4) $display("FAIL st_next got=%b/%h exp=1/%h", insn_valid, insn_pc, t + 32'h4); else n_pass++;
        ovr_en = 1'b0;
    endtask

    task automatic test_redirect_drain();
        for (int p = 0; p < 2; p++) begin
            bit found = 0;
            logic [31:0] exp_t = (p == 1) ? 32'h9000_0044 : 32'h8002_0100;
            lat = 0; slow_addr = 32'h8002_0010; slow_lat = 3;
            do_reset();
            enable = 1'b1;
            for (int i = 0; i < 20 && !found; i++) begin
                tick();
                #2;
                if (mem_req && mem_addr == 32'h8002_0010) found = 1;
            end
            n_total++; if (!found) $display("FAIL rd_req p=%0d got=none exp=80020010", p); else n_pass++;
            tick();
            redirect = 1'b1; redirect_pc = 32'h8002_0103;
            #2;
            n_total++; if (mem_req !== 1'b1 || mem_addr !== 32'h8002_0010) $display("FAIL rd_hold1 p=%0d got=%b/%h exp=1/80020010", p, mem_req, mem_addr); else n_pass++;
            tick();
            redirect = (p == 1); redirect_pc = 32'h9000_0046;
            #2;
            n_total++; if (insn_valid !== 1'b0) $display("FAIL rd_flush p=%0d got=%b exp=0", p, insn_valid); else n_pass++;
            n_total++; if (mem_req !== 1'b1 || mem_addr !== 32'h8002_0010) $display("FAIL rd_hold2 p=%0d got=%b/%h exp=1/80020010", p, mem_req, mem_addr); else n_pass++;
            tick();
            redirect = 1'b0;
            #2;
            n_total++; if (mem_req !== 1'b1 || mem_addr !== 32'h8002_0010) $display("FAIL rd_hold3 p=%0d got=%b/%h exp=1/80020010", p, mem_req, mem_addr); else n_pass++;
            tick();
            #2;
            n_total++; if (insn_valid !== 1'b0) $display("FAIL rd_discard p=%0d got=%b/%h exp=0", p, insn_valid, insn_pc); else n_pass++;
            n_total++; if (mem_req !== 1'b1 || mem_addr !== exp_t) $display("FAIL rd_target p=%0d got=%b/%h exp=1/%h", p, mem_req, mem_addr, exp_t); else n_pass++;
            tick();
            #2;
            n_total++; if (insn_valid !== 1'b1 || insn_pc !== exp_t) $display("FAIL rd_first p=%0d got=%b/%h exp=1/%h", p, insn_valid, insn_pc, exp_t); else n_pass++;
            n_total++; if (insn !== mem_word(exp_t)) $display("FAIL rd_insn p=%0d got=%h exp=%h", p, insn, mem_word(exp_t)); else n_pass++;
        end
        slow_addr = 32'h1;
    endtask

    task automatic test_wrap_and_reset();
        bit found = 0;
        lat = 0;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0; enable = 1'b1;
        #2;
        n_total++; if (mem_req !== 1'b0) $display("FAIL wr_idle_req got=%b exp=0", mem_req); else n_pass++;
        tick();
        #2;
        n_total++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) $display("FAIL wr_top got=%b/%h exp=1/fffffffc", mem_req, mem_addr); else n_pass++;
        tick();
        #2;
        n_total++; if (mem_addr !== 32'h0) $display("FAIL wr_wrap got=%h exp=00000000", mem_addr); else n_pass++;
        n_total++; if (insn_valid !== 1'b1 || insn_pc !== 32'hFFFF_FFFC) $display("FAIL wr_insn_pc got=%b/%h exp=1/fffffffc", insn_valid, insn_pc); else n_pass++;
        lat = 3;
        tick();
        #2;
        n_total++; if (mem_req !== 1'b1 || mem_ack !== 1'b0) $display("FAIL wr_pending got=%b/%b exp=1/0", mem_req, mem_ack); else n_pass++;
        tick();
        reset_n = 1'b0;
        #1;
        n_total++; if (mem_req !== 1'b0) $display("FAIL mr_req got=%b exp=0", mem_req); else n_pass++;
        n_total++; if (insn_valid !== 1'b0) $display("FAIL mr_valid got=%b exp=0", insn_valid); else n_pass++;
        n_total++; if (mem_addr !== RST_PC) $display("FAIL mr_addr got=%h exp=%h", mem_addr, RST_PC); else n_pass++;
        tick();
        lat = 0;
        reset_n = 1'b1;
        #2;
        n_total++; if (mem_req !== 1'b0) $display("FAIL mr_release_req got=%b exp=0", mem_req); else n_pass++;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            #2;
            if (mem_req) found = 1;
        end
        n_total++; if (!found || mem_addr !== RST_PC) $display("FAIL mr_restart got=%b/%h exp=1/%h", found, mem_addr, RST_PC); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] model_pc = RST_PC;
        bit          exp_flush = 0;
        bit          hold_valid = 0;
        logic [31:0] hold_insn = '0;
        logic [31:0] hold_pc = '0;
        bit          prev_pending = 0;
        logic [31:0] prev_addr = '0;
        int          beats = 0;
        lat = -1;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (exp_flush) begin
                n_total++; if (insn_valid !== 1'b0) $display("FAIL rnd_flush c=%0d got=%b exp=0", c, insn_valid); else n_pass++;
            end
            if (hold_valid) begin
                n_total++; if (insn_valid !== 1'b1 || insn !== hold_insn || insn_pc !== hold_pc) $display("FAIL rnd_hold c=%0d got=%b/%h/%h exp=1/%h/%h", c, insn_valid, insn, insn_pc, hold_insn, hold_pc); else n_pass++;
            end
            stall = ($urandom_range(0, 99) < 30);
            enable = ($urandom_range(0, 99) < 90);
            redirect = ($urandom_range(0, 99) < 8);
            redirect_pc = $urandom;
            #2;
            if (prev_pending) begin
                n_total++; if (mem_req !== 1'b1 || mem_addr !== prev_addr) $display("FAIL rnd_proto c=%0d got=%b/%h exp=1/%h", c, mem_req, mem_addr, prev_addr); else n_pass++;
            end
            if (mem_req) begin
                n_total++; if (mem_addr[1:0] !== 2'b00) $display("FAIL rnd_align c=%0d got=%h exp=aligned", c, mem_addr); else n_pass++;
            end
            if (redirect) begin
                model_pc = redirect_pc & 32'hFFFF_FFFC;
                exp_flush = 1;
                hold_valid = 0;
            end else begin
                exp_flush = 0;
                if (insn_valid && !stall) begin
                    n_total++; if (insn_pc !== model_pc) $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, insn_pc, model_pc); else n_pass++;
                    n_total++; if (insn !== mem_word(model_pc)) $display("FAIL rnd_insn c=%0d got=%h exp=%h", c, insn, mem_word(model_pc)); else n_pass++;
                    model_pc = model_pc + 32'h4;
                    beats++;
                end
                hold_valid = insn_valid && stall;
                hold_insn = insn;
                hold_pc = insn_pc;
            end
            prev_pending = mem_req && !mem_ack;
            prev_addr = mem_addr;
        end
        redirect = 1'b0;
        stall = 1'b0;
        n_total++; if (beats < 300) $display("FAIL rnd_throughput got=%0d exp>=300", beats); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_drain();
        test_wrap_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
